regs_wb: RTL and testbench

//   Integer register file x0..x31; write-back target of the combinational ex stage.
//   - Two combinational read ports feed the id stage.
//   - One write port is driven directly by ex (rd_addr/rd_data/rd_wen).
//   - Debug port with req/gnt handshake: registered reads, arbitrated writes.
//   - Starvation counter raises a hold request to ctrl when debug writes are blocked.

---
 rtl/regs_wb_if.sv | 34 +++
 rtl/regs_wb.sv | 134 +++++++++++++
 tb/tb_regs_wb.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/regs_wb_if.sv
// Bus bundle between the id/ex/debug side and the integer register file.
// master drives addresses, write data and debug requests; slave returns read data and handshake.
interface regs_wb_if #(
   parameter int DW = 32,
   parameter int AW = 5
);
   logic [AW-1:0] reg1_raddr_i;
   logic [AW-1:0] reg2_raddr_i;
   logic [DW-1:0] reg1_rdata_o;
   logic [DW-1:0] reg2_rdata_o;
   logic [AW-1:0] reg_waddr_i;
   logic [DW-1:0] reg_wdata_i;
   logic          reg_wen_i;
   logic          dbg_req_i;
   logic          dbg_we_i;
   logic [AW-1:0] dbg_addr_i;
   logic [DW-1:0] dbg_wdata_i;
   logic          dbg_gnt_o;
   logic          dbg_rvalid_o;
   logic [DW-1:0] dbg_rdata_o;
   logic          dbg_hold_o;

   modport master (
      output reg1_raddr_i, reg2_raddr_i, reg_waddr_i, reg_wdata_i, reg_wen_i,
             dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
      input  reg1_rdata_o, reg2_rdata_o, dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o, dbg_hold_o
   );

   modport slave (
      input  reg1_raddr_i, reg2_raddr_i, reg_waddr_i, reg_wdata_i, reg_wen_i,
             dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
      output reg1_rdata_o, reg2_rdata_o, dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o, dbg_hold_o
   );
endinterface

// File: rtl/regs_wb.sv
// Integer register file x0..x31 with two bypassed read ports, an ex write port and an
// arbitrated debug port whose blocked writes raise a pipeline hold request after a while.
//
// Hold FSM:
//   state   | meaning
//   ST_IDLE | no hold requested; starve counter may be running
//   ST_HOLD | debug write starved for STARVE_LIM cycles; asking ctrl to stall
module regs_wb #(
   parameter int            DW         = 32,
   parameter int            AW         = 5,
   parameter logic [DW-1:0] RESET_VAL  = '0,
   parameter int            STARVE_LIM = 4
) (
   input logic       clk,
   input logic       rst_n,
   regs_wb_if.slave  bus
);

   localparam int            NREG = 2**AW;
   localparam int            CW   = $clog2(STARVE_LIM + 1);
   localparam logic [CW-1:0] LIM  = CW'(STARVE_LIM);

   typedef enum logic {ST_IDLE, ST_HOLD} state_t;

   logic [DW-1:0] regs [NREG];

   logic          dbg_gnt;
   logic          core_wr;
   logic          dbg_wr;
   logic          dbg_rd;
   logic          commit_en;
   logic [AW-1:0] commit_addr;
   logic [DW-1:0] commit_data;
   logic [DW-1:0] dbg_rd_val;

   logic          dbg_rvalid_q;
   logic [DW-1:0] dbg_rdata_q;

   logic          dbg_denied;
   logic          starve_hit;
   logic [CW-1:0] starve_cnt;

   state_t        state_q;
   state_t        state_d;
   logic          hold;

   // Core write has priority; debug reads never collide with it.
   assign dbg_gnt = rst_n & bus.dbg_req_i & ~(bus.dbg_we_i & bus.reg_wen_i);
   assign core_wr = rst_n & bus.reg_wen_i;
   assign dbg_wr  = dbg_gnt & bus.dbg_we_i;
   assign dbg_rd  = dbg_gnt & ~bus.dbg_we_i;

   assign commit_addr = core_wr ? bus.reg_waddr_i : bus.dbg_addr_i;
   assign commit_data = core_wr ? bus.reg_wdata_i : bus.dbg_wdata_i;
   assign commit_en   = (core_wr | dbg_wr) & (commit_addr != '0);

   // commit_en already excludes x0, so a matching address is always a live register.
   assign bus.reg1_rdata_o = (!rst_n || bus.reg1_raddr_i == '0) ? '0 :
                             (commit_en && commit_addr == bus.reg1_raddr_i) ? commit_data :
                             regs[bus.reg1_raddr_i];
   assign bus.reg2_rdata_o = (!rst_n || bus.reg2_raddr_i == '0) ? '0 :
                             (commit_en && commit_addr == bus.reg2_raddr_i) ? commit_data :
                             regs[bus.reg2_raddr_i];
   assign dbg_rd_val       = (bus.dbg_addr_i == '0) ? '0 :
                             (commit_en && commit_addr == bus.dbg_addr_i) ? commit_data :
                             regs[bus.dbg_addr_i];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= (i == 0) ? '0 : RESET_VAL;
         end
      end else if (commit_en) begin
         regs[commit_addr] <= commit_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dbg_rvalid_q <= 1'b0;
         dbg_rdata_q  <= '0;
      end else begin
         dbg_rvalid_q <= dbg_rd;
         if (dbg_rd) begin
            dbg_rdata_q <= dbg_rd_val;
         end
      end
   end

   // A read granted just before reset must not surface while reset is held.
   assign bus.dbg_gnt_o    = dbg_gnt;
   assign bus.dbg_rvalid_o = dbg_rvalid_q & rst_n;
   assign bus.dbg_rdata_o  = dbg_rdata_q;

   assign dbg_denied = rst_n & bus.dbg_req_i & bus.dbg_we_i & ~dbg_gnt;
   assign starve_hit = dbg_denied & (starve_cnt == LIM);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (!dbg_denied) begin
         starve_cnt <= '0;
      end else if (starve_cnt != LIM) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (starve_hit)  state_d = ST_HOLD;
         ST_HOLD: if (!dbg_denied) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      hold = 1'b0;
      if (state_q == ST_HOLD) begin
         hold = 1'b1;
      end
   end

   assign bus.dbg_hold_o = hold;

endmodule

// File: tb/tb_regs_wb.sv
// Bench for regs_wb: table of single-cycle vectors plus hand-written reset, starvation
// and reset-during-read sequences; debug read data is scoreboarded through a queue.
module tb_regs_wb;

   localparam int DW = 32;
   localparam int AW = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   regs_wb_if #(.DW(DW), .AW(AW)) bus ();

   regs_wb #(
      .DW(DW), .AW(AW), .RESET_VAL('0), .STARVE_LIM(4)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   typedef struct {
      string       name;
      logic        wen;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        req;
      logic        we;
      logic [4:0]  daddr;
      logic [31:0] dwdata;
      logic [4:0]  r1;
      logic [4:0]  r2;
      logic        exp_gnt;
      logic [31:0] exp_rd1;
      logic [31:0] exp_rd2;
      logic [31:0] exp_dbg;
   } vec_t;

   vec_t        vecs[13];
   int          vec_cnt  = 0;
   int          miss_cnt = 0;
   logic [31:0] sb_q[$];

   function automatic vec_t mk(string name, logic wen, logic [4:0] waddr, logic [31:0] wdata,
                               logic req, logic we, logic [4:0] daddr, logic [31:0] dwdata,
                               logic [4:0] r1, logic [4:0] r2, logic exp_gnt,
                               logic [31:0] exp_rd1, logic [31:0] exp_rd2, logic [31:0] exp_dbg);
      vec_t v;
      v.name = name; v.wen = wen; v.waddr = waddr; v.wdata = wdata;
      v.req = req; v.we = we; v.daddr = daddr; v.dwdata = dwdata;
      v.r1 = r1; v.r2 = r2; v.exp_gnt = exp_gnt;
      v.exp_rd1 = exp_rd1; v.exp_rd2 = exp_rd2; v.exp_dbg = exp_dbg;
      return v;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.reg1_raddr_i = '0;
      bus.reg2_raddr_i = '0;
      bus.reg_waddr_i  = '0;
      bus.reg_wdata_i  = '0;
      bus.reg_wen_i    = 1'b0;
      bus.dbg_req_i    = 1'b0;
      bus.dbg_we_i     = 1'b0;
      bus.dbg_addr_i   = '0;
      bus.dbg_wdata_i  = '0;
   endtask

   // Advance one clock and reconcile debug read responses against the scoreboard.
   task automatic step();
      logic        exp_rv;
      logic [31:0] exp_data;
      @(posedge clk);
      #1;
      exp_rv = (sb_q.size() > 0);
      check("dbg_rvalid", {31'b0, bus.dbg_rvalid_o}, {31'b0, exp_rv});
      if (exp_rv) begin
         exp_data = sb_q.pop_front();
         if (bus.dbg_rvalid_o) check("dbg_rdata", bus.dbg_rdata_o, exp_data);
      end
   endtask

   task automatic apply(vec_t v);
      bus.reg_wen_i    = v.wen;
      bus.reg_waddr_i  = v.waddr;
      bus.reg_wdata_i  = v.wdata;
      bus.dbg_req_i    = v.req;
      bus.dbg_we_i     = v.we;
      bus.dbg_addr_i   = v.daddr;
      bus.dbg_wdata_i  = v.dwdata;
      bus.reg1_raddr_i = v.r1;
      bus.reg2_raddr_i = v.r2;
      #1;
      check({v.name, ".gnt"}, {31'b0, bus.dbg_gnt_o}, {31'b0, v.exp_gnt});
      check({v.name, ".rd1"}, bus.reg1_rdata_o, v.exp_rd1);
      check({v.name, ".rd2"}, bus.reg2_rdata_o, v.exp_rd2);
      if (v.exp_gnt && v.req && !v.we) sb_q.push_back(v.exp_dbg);
      step();
   endtask

   initial begin
      vecs[0]  = mk("wr_bypass",   1, 5,  32'hDEADBEEF, 0, 0, 0,  0,            5,  0,  0, 32'hDEADBEEF, 0,            0);
      vecs[1]  = mk("wr_stored",   0, 0,  0,            0, 0, 0,  0,            5,  5,  0, 32'hDEADBEEF, 32'hDEADBEEF, 0);
      vecs[2]  = mk("core_x0",     1, 0,  32'h1234,     0, 0, 0,  0,            0,  5,  0, 0,            32'hDEADBEEF, 0);
      vecs[3]  = mk("dbg_x0",      0, 0,  0,            1, 1, 0,  32'h55,       0,  0,  1, 0,            0,            0);
      vecs[4]  = mk("x0_read",     0, 0,  0,            0, 0, 0,  0,            0,  5,  0, 0,            32'hDEADBEEF, 0);
      vecs[5]  = mk("wr_x7",       1, 7,  32'hA5A5A5A5, 0, 0, 0,  0,            7,  0,  0, 32'hA5A5A5A5, 0,            0);
      vecs[6]  = mk("dbg_rd_x7",   1, 9,  32'h11,       1, 0, 7,  0,            9,  7,  1, 32'h11,       32'hA5A5A5A5, 32'hA5A5A5A5);
      vecs[7]  = mk("dbg_rd_byp",  1, 9,  32'h22,       1, 0, 9,  0,            9,  0,  1, 32'h22,       0,            32'h22);
      vecs[8]  = mk("dbg_wr_x3",   0, 0,  0,            1, 1, 3,  32'h33,       3,  9,  1, 32'h33,       32'h22,       0);
      vecs[9]  = mk("dbg_wr_lose", 1, 6,  32'h66,       1, 1, 4,  32'h44,       4,  6,  0, 0,            32'h66,       0);
      vecs[10] = mk("after_lose",  0, 0,  0,            0, 0, 0,  0,            4,  6,  0, 0,            32'h66,       0);
      vecs[11] = mk("dbg_wr_x31",  0, 0,  0,            1, 1, 31, 32'hF0F0F0F0, 31, 3,  1, 32'hF0F0F0F0, 32'h33,       0);
      vecs[12] = mk("dbg_rd_x31",  0, 0,  0,            1, 0, 31, 0,            3,  31, 1, 32'h33,       32'hF0F0F0F0, 32'hF0F0F0F0);

      // Reset held for two clocks; outputs gated while it is low.
      idle_inputs();
      rst_n = 1'b0;
      step();
      step();
      bus.dbg_req_i = 1'b1;
      bus.reg1_raddr_i = 5'd1;
      #1;
      check("rst.gnt", {31'b0, bus.dbg_gnt_o}, 32'd0);
      idle_inputs();
      rst_n = 1'b1;
      for (int a = 1; a < 32; a++) begin
         bus.reg1_raddr_i = a[4:0];
         bus.reg2_raddr_i = 5'(32 - a);
         #1;
         check("rst.x_rd1", bus.reg1_rdata_o, 32'd0);
         check("rst.x_rd2", bus.reg2_rdata_o, 32'd0);
      end
      check("rst.rvalid", {31'b0, bus.dbg_rvalid_o}, 32'd0);
      check("rst.hold", {31'b0, bus.dbg_hold_o}, 32'd0);
      idle_inputs();

      for (int i = 0; i < 13; i++) apply(vecs[i]);

      idle_inputs();
      step();
      check("rdata_hold", bus.dbg_rdata_o, 32'hF0F0F0F0);

      // Continuous core writes starve a debug write to x3.
      bus.reg_wen_i   = 1'b1;
      bus.reg_waddr_i = 5'd12;
      bus.reg_wdata_i = 32'h1;
      bus.dbg_req_i   = 1'b1;
      bus.dbg_we_i    = 1'b1;
      bus.dbg_addr_i  = 5'd3;
      bus.dbg_wdata_i = 32'h77;
      for (int e = 1; e <= 7; e++) begin
         #1;
         check("starve.gnt", {31'b0, bus.dbg_gnt_o}, 32'd0);
         step();
         check("starve.hold", {31'b0, bus.dbg_hold_o}, (e >= 5) ? 32'd1 : 32'd0);
      end
      bus.reg_wen_i = 1'b0;
      #1;
      check("release.gnt", {31'b0, bus.dbg_gnt_o}, 32'd1);
      check("release.hold", {31'b0, bus.dbg_hold_o}, 32'd1);
      step();
      check("release.hold_drop", {31'b0, bus.dbg_hold_o}, 32'd0);
      idle_inputs();
      bus.reg1_raddr_i = 5'd3;
      #1;
      check("release.x3", bus.reg1_rdata_o, 32'h77);
      step();

      // Hold also drops once the debug request is withdrawn.
      bus.reg_wen_i   = 1'b1;
      bus.reg_waddr_i = 5'd13;
      bus.reg_wdata_i = 32'h2;
      bus.dbg_req_i   = 1'b1;
      bus.dbg_we_i    = 1'b1;
      bus.dbg_addr_i  = 5'd4;
      bus.dbg_wdata_i = 32'h5;
      for (int e = 1; e <= 5; e++) step();
      check("withdraw.hold_up", {31'b0, bus.dbg_hold_o}, 32'd1);
      bus.dbg_req_i = 1'b0;
      step();
      check("withdraw.hold_drop", {31'b0, bus.dbg_hold_o}, 32'd0);
      idle_inputs();
      bus.reg1_raddr_i = 5'd4;
      #1;
      check("withdraw.x4", bus.reg1_rdata_o, 32'd0);

      // A granted read followed by reset never produces a response.
      idle_inputs();
      bus.dbg_req_i  = 1'b1;
      bus.dbg_addr_i = 5'd7;
      #1;
      check("rstrd.gnt", {31'b0, bus.dbg_gnt_o}, 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      idle_inputs();
      bus.dbg_req_i    = 1'b1;
      bus.reg1_raddr_i = 5'd5;
      #1;
      check("rstrd.rvalid", {31'b0, bus.dbg_rvalid_o}, 32'd0);
      check("rstrd.rd1", bus.reg1_rdata_o, 32'd0);
      check("rstrd.gnt_low", {31'b0, bus.dbg_gnt_o}, 32'd0);
      step();
      idle_inputs();
      rst_n = 1'b1;
      bus.reg1_raddr_i = 5'd7;
      bus.reg2_raddr_i = 5'd5;
      #1;
      check("rstrd.x7", bus.reg1_rdata_o, 32'd0);
      check("rstrd.x5", bus.reg2_rdata_o, 32'd0);
      check("rstrd.hold", {31'b0, bus.dbg_hold_o}, 32'd0);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
